dsp_mac_sequencer: RTL and testbench
====================================

// Module: dsp_mac_sequencer
// PURPOSE
//  Shares one DSP48A1-style multiply-accumulate slice between two requesters.
//  Round-robin arbiter grants a whole burst (operand pairs up to a 'last' beat).
//  First beat issues MUL, later beats MAC; sequencer then drains the slice pipeline
//  and returns the accumulated P with the owner's ID.
//  Sits between client engines and the slice; slice latency set by its pipeline configuration.
// PARAMETERS
//  WIDTH    18  operand width of A and B
//  PWIDTH   48  accumulator/result width
//  LATENCY  4   slice cycles with dsp_ce=1 from dsp_a/dsp_b to valid dsp_p (>=1)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   2          per-requester beat valid
//  req_ready  out  2          per-requester beat accept (owner only, BURST only)
//  req_a      in   2*WIDTH    operand A; requester i at [i*WIDTH +: WIDTH]
//  req_b      in   2*WIDTH    operand B; same packing
//  req_last   in   2          marks final beat of a burst
//  dsp_a      out  WIDTH      registered operand A to slice
//  dsp_b      out  WIDTH      registered operand B to slice
//  dsp_opmode out  8          OP_MUL / OP_MAC / OP_NOP encodings
//  dsp_ce     out  1          slice pipeline clock enable
//  dsp_p      in   PWIDTH     slice result
//  rsp_valid  out  1          one-cycle result pulse
//  rsp_id     out  1          requester owning the result
//  rsp_data   out  PWIDTH     registered accumulated result
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, all outputs 0, dsp_opmode=OP_NOP. Any burst in flight is discarded with no response.
//  FSM IDLE->GRANT: any req_valid set. Owner = rr_ptr if its valid is set, else the other requester.
//  Owner is registered; rr_ptr <= ~owner. The GRANT cycle lasts one clock with no ready.
//  BURST: req_ready[owner]=1, other ready 0. A beat is accepted when valid&ready.
//  Accepted beat at cycle t drives dsp_a/dsp_b at t+1, dsp_ce=1 at t+1.
//  dsp_opmode at t+1 is OP_MUL for the first beat of the burst, else OP_MAC.
//  Cycle with no accepted beat: dsp_ce=0 (pipeline frozen), opmode OP_NOP.
//  Accepted beat with last=1 -> DRAIN; first==last gives a single MUL.
//  DRAIN: dsp_ce=1 and opmode OP_NOP for LATENCY cycles, counted by a down-counter loaded with LATENCY.
//  The final DRAIN cycle captures dsp_p into rsp_data. rsp_valid=1 and rsp_id=owner on the next cycle, then IDLE.
//  Last-beat accept at t => rsp_valid at t+LATENCY+2. At least one IDLE cycle between bursts.
//  Non-owner valid during GRANT/BURST/DRAIN is ignored and never accepted.
//  Both valid in IDLE: rr_ptr wins, so alternating bursts are guaranteed under contention.
//  Arithmetic is performed in the slice only. The sequencer never modifies operand or result widths.
//  rsp_valid is a pulse with no backpressure; the consumer must take it.
// CONFIGURATION
//  `DSP_SEQ_PERF_EN defined: adds perf_busy_cnt[31:0], a count of cycles with state!=IDLE.
//  It also adds perf_burst_cnt[15:0], a count of rsp_valid pulses. Both saturate, and both clear on rst.
//  `DSP_SEQ_PERF_EN undefined: neither port nor counter exists; behaviour is otherwise identical.
// STRUCTURE
//  dsp_seq_pkg (shared include): OP_MUL/OP_MAC/OP_NOP 8-bit opmode constants, plus state encodings.
//  State encodings: IDLE=0, GRANT=1, BURST=2, DRAIN=3.
//  Sub-module rr_arbiter2: 2-way round-robin, inputs req[1:0]/ptr, outputs grant id. Purely combinational.
//  Top holds the FSM, owner/rr_ptr registers, drain counter, dsp output registers, and response register.
// TESTING
//  Single beat: req0 a=3,b=5,last=1 -> opmode MUL; rsp_valid at accept+LATENCY+2 with id=0, data=15.
//  Burst of 3: req1 (2,4),(3,3),(1,7 last) -> MUL,MAC,MAC; rsp id=1, data=24.
//  Contention: both valid from reset -> req0 served first, then req1, then req0. Never two consecutive grants to one requester while the other waits.
//  Gaps: owner drops valid 3 cycles mid-burst -> dsp_ce=0 in those cycles; the result is unchanged.
//  Reset mid-DRAIN: rst=1 for 1 cycle -> no rsp_valid, outputs 0, next grant goes to req0.
//  Under `DSP_SEQ_PERF_EN: two 1-beat bursts -> perf_burst_cnt=2, perf_busy_cnt=2*(LATENCY+3).

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: opmode constants and sequencer state encodings shared by the MAC sequencer.
package dsp_seq_pkg;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_MUL = 8'h01;
    localparam logic [7:0] OP_MAC = 8'h09;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BURST = 2'd2,
        S_DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/dsp_mac_sequencer_rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin pick; the pointed-to requester wins if it is asking.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant
);
    assign grant = req[ptr] ? ptr : ~ptr;
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: shares one MAC slice between two requesters, one whole burst per grant.
// Define DSP_SEQ_PERF_EN to add saturating busy-cycle and response counters.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int PWIDTH  = 48,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DSP_SEQ_PERF_EN
    output logic [31:0]          perf_busy_cnt,
    output logic [15:0]          perf_burst_cnt,
`endif
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [1:0]           req_last,
    output logic [WIDTH-1:0]     dsp_a,
    output logic [WIDTH-1:0]     dsp_b,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_ce,
    input  logic [PWIDTH-1:0]    dsp_p,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [PWIDTH-1:0]    rsp_data
);
    localparam int CW = $clog2(LATENCY + 1);

    state_t            r_state, w_next;
    logic              r_owner, r_rr_ptr, r_first, w_grant;
    logic [CW-1:0]     r_cnt;
    logic              w_accept, w_last, w_ce_d, w_rsp_d;
    logic [7:0]        w_op_d;
    logic [WIDTH-1:0]  w_a, w_b;

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    assign req_ready = (r_state == S_BURST) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign w_accept  = |(req_valid & req_ready);
    assign w_last    = req_last[r_owner];
    assign w_a       = r_owner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign w_b       = r_owner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Drain keeps the slice clocked until the last beat's result reaches dsp_p.
    always_comb begin
        w_next  = r_state;
        w_ce_d  = w_accept || (r_state == S_DRAIN && r_cnt != '0);
        w_op_d  = w_accept ? (r_first ? OP_MUL : OP_MAC) : OP_NOP;
        w_rsp_d = (r_state == S_DRAIN) && (r_cnt == '0);
        unique case (r_state)
            S_IDLE:  w_next = |req_valid ? S_GRANT : S_IDLE;
            S_GRANT: w_next = S_BURST;
            S_BURST: w_next = (w_accept && w_last) ? S_DRAIN : S_BURST;
            S_DRAIN: w_next = (r_cnt == '0) ? S_IDLE : S_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_first    <= 1'b0;
            r_cnt      <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= OP_NOP;
            dsp_ce     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            if (r_state == S_IDLE && |req_valid) begin
                r_owner  <= w_grant;
                r_rr_ptr <= ~w_grant;
            end
            r_first <= (r_state == S_GRANT) ? 1'b1 : (w_accept ? 1'b0 : r_first);
            r_cnt   <= (w_accept && w_last) ? CW'(LATENCY) :
                       (r_state == S_DRAIN && r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
            if (w_accept) begin
                dsp_a <= w_a;
                dsp_b <= w_b;
            end
            dsp_ce     <= w_ce_d;
            dsp_opmode <= w_op_d;
            rsp_valid  <= w_rsp_d;
            if (w_rsp_d) begin
                rsp_id   <= r_owner;
                rsp_data <= dsp_p;
            end
        end
    end

`ifdef DSP_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cnt  <= '0;
            perf_burst_cnt <= '0;
        end else begin
            if (r_state != S_IDLE && perf_busy_cnt != '1) perf_busy_cnt <= perf_busy_cnt + 32'd1;
            if (rsp_valid && perf_burst_cnt != '1) perf_burst_cnt <= perf_burst_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: random and directed bursts against a slice model and a burst-level scoreboard.
module tb_dsp_mac_sequencer;
    import dsp_seq_pkg::*;
    localparam int W = 18, PW = 48, L = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic v [2], rl [2];
    logic [W-1:0] ra [2], rb [2];
    logic [1:0] req_valid, req_ready, req_last;
    logic [2*W-1:0] req_a, req_b;
    logic [W-1:0] dsp_a, dsp_b;
    logic [7:0] dsp_opmode;
    logic dsp_ce, rsp_valid, rsp_id;
    logic [PW-1:0] dsp_p, rsp_data;
`ifdef DSP_SEQ_PERF_EN
    logic [31:0] perf_busy_cnt;
    logic [15:0] perf_burst_cnt;
`endif

    assign req_valid = {v[1], v[0]};
    assign req_last  = {rl[1], rl[0]};
    assign req_a     = {ra[1], ra[0]};
    assign req_b     = {rb[1], rb[0]};

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.WIDTH(W), .PWIDTH(PW), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
`ifdef DSP_SEQ_PERF_EN
        .perf_busy_cnt(perf_busy_cnt), .perf_burst_cnt(perf_burst_cnt),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_last(req_last), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_p(dsp_p), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint x;
        x = longint'($signed(a)) * longint'($signed(b));
        return x[PW-1:0];
    endfunction

    // Slice model: L enabled clocks from operands to P; MUL loads, MAC accumulates, NOP clears.
    logic [PW-1:0] s_m [L];
    logic [7:0]    s_op [L];
    logic [PW-1:0] p = '0;
    initial for (int i = 0; i < L; i++) begin s_m[i] = '0; s_op[i] = OP_NOP; end
    assign dsp_p = p;
    always @(posedge clk) if (dsp_ce) begin
        s_m[0]  <= mul(dsp_a, dsp_b);
        s_op[0] <= dsp_opmode;
        for (int i = 1; i < L; i++) begin s_m[i] <= s_m[i-1]; s_op[i] <= s_op[i-1]; end
        p <= (s_op[L-2] == OP_MUL) ? s_m[L-2] : (s_op[L-2] == OP_MAC) ? p + s_m[L-2] : '0;
    end

    // Burst-level reference: expected response = sum of products, due L+1 edges after the last accept.
    typedef struct { int id; logic [PW-1:0] data; int due; } rsp_t;
    rsp_t exp_q [$];
    int id_log [$];
    int cyc = 0, drain_to = -1;
    bit chk_en = 0, in_b [2], acc, acc_first, two_acc;
    logic [W-1:0] acc_a, acc_b;
    logic [PW-1:0] sum [2], last_data;
    int last_id;

    always @(posedge clk) begin
        cyc++;
        acc = 0;
        two_acc = (req_valid & req_ready) == 2'b11;
        if (rst) begin
            exp_q.delete();
            drain_to = -1;
            in_b[0] = 0; in_b[1] = 0;
        end else for (int i = 0; i < 2; i++) if (req_valid[i] && req_ready[i]) begin
            acc = 1; acc_a = ra[i]; acc_b = rb[i];
            acc_first = !in_b[i];
            sum[i] = (acc_first ? '0 : sum[i]) + mul(ra[i], rb[i]);
            in_b[i] = 1;
            if (rl[i]) begin
                exp_q.push_back('{i, sum[i], cyc + L + 1});
                in_b[i] = 0;
                drain_to = cyc + L;
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("dsp_ce", dsp_ce, acc || (cyc <= drain_to));
        chk("dsp_opmode", dsp_opmode, acc ? (acc_first ? OP_MUL : OP_MAC) : OP_NOP);
        if (acc) begin
            chk("dsp_a", dsp_a, acc_a);
            chk("dsp_b", dsp_b, acc_b);
        end
        if (two_acc) chk("single_owner", 1, 0);
        if (rsp_valid) begin
            last_data = rsp_data; last_id = rsp_id; id_log.push_back(int'(rsp_id));
            if (exp_q.size() == 0) chk("rsp_spurious", 1, 0);
            else begin
                chk("rsp_cycle", cyc, exp_q[0].due);
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_data", rsp_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            chk("rsp_missing", 0, 1);
            void'(exp_q.pop_front());
        end
    end

    task automatic burst(input int i, input int n, input logic [W-1:0] av [8],
                         input logic [W-1:0] bv [8], input int gap_at, input int gap_len);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            if (k == gap_at && k > 0) begin
                v[i] = 0;
                repeat (gap_len) @(negedge clk);
            end
            v[i] = 1; ra[i] = av[k]; rb[i] = bv[k]; rl[i] = (k == n - 1);
            while (!req_ready[i] && w < 200) begin @(negedge clk); w++; end
            chk("accept_wait", w < 200, 1);
            @(negedge clk);
        end
        v[i] = 0; rl[i] = 0;
    endtask

    task automatic burst_rand(input int i);
        logic [W-1:0] av [8], bv [8];
        int n = $urandom_range(1, 6);
        for (int k = 0; k < 8; k++) begin
            av[k] = W'($urandom_range(0, 18'h3FFFF));
            bv[k] = W'($urandom_range(0, 18'h3FFFF));
        end
        burst(i, n, av, bv, $urandom_range(0, n - 1), $urandom_range(0, 3));
    endtask

    task automatic wait_done();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin @(negedge clk); w++; end
        chk("rsp_wait", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        repeat (n) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [W-1:0] av [8], bv [8];
        for (int i = 0; i < 2; i++) begin v[i] = 0; rl[i] = 0; ra[i] = '0; rb[i] = '0; end
        @(negedge clk);
        do_reset(3);
        chk("rst_dsp_a", dsp_a, 0);
        chk("rst_dsp_b", dsp_b, 0);
        chk("rst_opmode", dsp_opmode, OP_NOP);
        chk("rst_ce", dsp_ce, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ready", req_ready, 0);
        chk_en = 1;
`ifdef DSP_SEQ_PERF_EN
        for (int k = 0; k < 8; k++) begin av[k] = W'(k + 1); bv[k] = W'(k + 2); end
        burst(0, 1, av, bv, 0, 0); wait_done();
        burst(0, 1, av, bv, 0, 0); wait_done();
        chk("perf_burst", perf_burst_cnt, 2);
        chk("perf_busy", perf_busy_cnt, 2 * (L + 3));
        do_reset(1);
`endif
        av[0] = 3; bv[0] = 5;
        burst(0, 1, av, bv, 0, 0); wait_done();
        chk("single_data", last_data, 15);
        chk("single_id", last_id, 0);
        av[0] = 2; bv[0] = 4; av[1] = 3; bv[1] = 3; av[2] = 1; bv[2] = 7;
        burst(1, 3, av, bv, 0, 0); wait_done();
        chk("burst3_data", last_data, 24);
        chk("burst3_id", last_id, 1);
        for (int k = 0; k < 8; k++) begin av[k] = W'($urandom_range(0, 999)); bv[k] = W'($urandom_range(0, 999)); end
        burst(0, 4, av, bv, 2, 3); wait_done();
        for (int it = 0; it < 20; it++) begin
            int mode = $urandom_range(0, 2);
            fork
                begin if (mode != 1) burst_rand(0); end
                begin if (mode != 0) burst_rand(1); end
            join
            wait_done();
        end
        do_reset(1);
        id_log.delete();
        fork
            begin burst_rand(0); burst_rand(0); end
            begin burst_rand(1); burst_rand(1); end
        join
        wait_done();
        chk("rr_count", id_log.size(), 4);
        for (int k = 0; k < 4; k++) if (k < id_log.size()) chk("rr_order", id_log[k], k % 2);
        burst(0, 1, av, bv, 0, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_ce", dsp_ce, 0);
        chk("mid_rst_a", dsp_a, 0);
        chk("mid_rst_opmode", dsp_opmode, OP_NOP);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        id_log.delete();
        fork
            burst_rand(0);
            burst_rand(1);
        join
        wait_done();
        chk("post_rst_count", id_log.size(), 2);
        if (id_log.size() > 0) chk("post_rst_first", id_log[0], 0);
        repeat (L + 4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
